// File: rtl/jtframe_ps2_cmd.sv
// PS/2 host-to-keyboard command sequencer: sends a command byte plus an optional argument,
// waits for the keyboard's ack/response, and retries on 0xFE or timeout.
module jtframe_ps2_cmd #(
    parameter int INHIBIT_CYC = 4800,
    parameter int TIMEOUT_CYC = 96000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_fwd_valid,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_err
);

    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACKBIT,
        S_WAIT_RESP,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic [7:0]       cmd_arg_q, cmd_arg_d;
    logic             has_arg_q, has_arg_d;
    logic             arg_sel_q, arg_sel_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_last_q;

    logic             dev_fall;
    logic             timeout;
    logic             do_retry;
    logic [7:0]       cur_byte;
    logic [15:0]      frame;

    assign dev_fall = clk_last_q & ~clk_sync_q[1];
    assign timeout  = (cnt_q == TMO_LAST);
    assign cur_byte = arg_sel_q ? cmd_arg_q : cmd_byte_q;
    // Index 0 is the start bit; upper padding keeps a 4-bit index in range
    assign frame    = {5'h1F, 1'b1, ~^cur_byte, cur_byte, 1'b0};

    // Synchronisers idle high so release from reset never looks like a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_last_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_last_q  <= clk_sync_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            retry_q    <= '0;
            cmd_byte_q <= '0;
            cmd_arg_q  <= '0;
            has_arg_q  <= 1'b0;
            arg_sel_q  <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            retry_q    <= retry_d;
            cmd_byte_q <= cmd_byte_d;
            cmd_arg_q  <= cmd_arg_d;
            has_arg_q  <= has_arg_d;
            arg_sel_q  <= arg_sel_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        retry_d    = retry_q;
        cmd_byte_d = cmd_byte_q;
        cmd_arg_d  = cmd_arg_q;
        has_arg_d  = has_arg_q;
        arg_sel_d  = arg_sel_q;
        do_retry   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_req) begin
                    cmd_byte_d = cmd_byte;
                    cmd_arg_d  = cmd_arg;
                    has_arg_d  = cmd_has_arg;
                    arg_sel_d  = 1'b0;
                    retry_d    = '0;
                    cnt_d      = '0;
                    state_d    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (dev_fall) begin
                    cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        state_d = S_ACKBIT;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else if (timeout) begin
                    do_retry = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACKBIT: begin
                if (dev_fall) begin
                    cnt_d = '0;
                    if (!data_sync_q[1]) begin
                        state_d = S_WAIT_RESP;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (timeout) begin
                    do_retry = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_RESP: begin
                if (rx_valid && rx_byte == 8'hFA) begin
                    retry_d = '0;
                    cnt_d   = '0;
                    if (!arg_sel_q && has_arg_q) begin
                        arg_sel_d = 1'b1;
                        state_d   = S_INHIBIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (rx_valid && rx_byte == 8'hFE) begin
                    do_retry = 1'b1;
                end else if (timeout) begin
                    do_retry = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A retry resends only the byte in progress; arg_sel_q is left untouched
        if (do_retry) begin
            cnt_d = '0;
            if (retry_q == RTY_MAX) begin
                state_d = S_ERR;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = S_INHIBIT;
            end
        end

        // Outputs are registered from the next state so they line up with state_q
        clk_oe_d  = (state_d == S_INHIBIT);
        data_oe_d = ((state_d == S_INHIBIT) && (cnt_d == INH_LAST)) ||
                    ((state_d == S_SEND) && !frame[bit_d]);
        busy_d    = (state_d == S_INHIBIT) || (state_d == S_SEND) ||
                    (state_d == S_ACKBIT)  || (state_d == S_WAIT_RESP);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
    end

    always_comb begin
        rx_fwd_valid = 1'b0;
        case (state_q)
            S_INHIBIT, S_SEND, S_ACKBIT: rx_fwd_valid = 1'b0;
            S_WAIT_RESP: rx_fwd_valid = rx_valid && (rx_byte != 8'hFA) && (rx_byte != 8'hFE);
            default:     rx_fwd_valid = rx_valid;
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign cmd_busy    = busy_q;
    assign cmd_done    = done_q;
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_jtframe_ps2_cmd.sv
// Directed bench for jtframe_ps2_cmd with a wired-AND PS/2 line and a simple keyboard model.
module tb_jtframe_ps2_cmd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_fwd_valid;
    logic       cmd_req = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = 8'h00;
    logic       cmd_busy, cmd_done, cmd_err;

    always #5 clk = ~clk;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    jtframe_ps2_cmd #(
        .INHIBIT_CYC(16),
        .TIMEOUT_CYC(200),
        .MAX_RETRY  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_fwd_valid(rx_fwd_valid),
        .cmd_req     (cmd_req),
        .cmd_byte    (cmd_byte),
        .cmd_has_arg (cmd_has_arg),
        .cmd_arg     (cmd_arg),
        .cmd_busy    (cmd_busy),
        .cmd_done    (cmd_done),
        .cmd_err     (cmd_err)
    );

    int checks = 0;
    int failures = 0;

    // Event counters sampled away from the active edge
    int done_cnt = 0, err_cnt = 0, fwd_cnt = 0, inh_cnt = 0;
    int inh_run = 0, last_inh = 0, both_hi = 0, bad_edge = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (cmd_done) done_cnt <= done_cnt + 1;
        if (cmd_err) err_cnt <= err_cnt + 1;
        if (rx_fwd_valid) fwd_cnt <= fwd_cnt + 1;
        if (cmd_done && cmd_err) both_hi <= both_hi + 1;
        if ((cmd_done || cmd_err) && !(busy_prev && !cmd_busy)) bad_edge <= bad_edge + 1;
        busy_prev <= cmd_busy;
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
        end else if (inh_run != 0) begin
            last_inh <= inh_run;
            inh_cnt  <= inh_cnt + 1;
            inh_run  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_cmd(input logic [7:0] b, input logic has, input logic [7:0] a);
        @(negedge clk);
        cmd_byte = b;
        cmd_has_arg = has;
        cmd_arg = a;
        cmd_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0;
        check("busy_after_accept", {31'b0, cmd_busy}, 1);
        cmd_byte = 8'h5A;
        cmd_arg = 8'hA5;
        cmd_has_arg = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) ok = 1'b1;
        end
        check("start_seen", {31'b0, ok}, 1);
    endtask

    // Keyboard side of one host-to-device frame, ending with an ack bit
    task automatic device_frame(output logic [10:0] cap);
        bit ok;
        cap = '1;
        wait_start(ok);
        if (ok) begin
            repeat (4) @(negedge clk);
            cap[0] = ps2_data_in;
            for (int i = 1; i <= 10; i++) begin
                dev_clk = 1'b0;
                repeat (8) @(negedge clk);
                dev_clk = 1'b1;
                cap[i] = ps2_data_in;
                repeat (8) @(negedge clk);
            end
            dev_data = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (8) @(negedge clk);
            dev_clk = 1'b1;
            repeat (2) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, output logic fwd);
        @(negedge clk);
        rx_byte = b;
        rx_valid = 1'b1;
        #1 fwd = rx_fwd_valid;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [10:0] cap;
    logic fwd;
    int d0, e0, f0, i0, err_at;
    bit ok;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clk_oe", {31'b0, ps2_clk_oe}, 0);
        check("rst_data_oe", {31'b0, ps2_data_oe}, 0);
        check("rst_busy", {31'b0, cmd_busy}, 0);
        check("rst_done_err", {30'b0, cmd_done, cmd_err}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Idle forwarding, including bytes that would be consumed mid-command
        send_rx(8'h1C, fwd);
        check("idle_fwd_1c", {31'b0, fwd}, 1);
        send_rx(8'hFA, fwd);
        check("idle_fwd_fa", {31'b0, fwd}, 1);

        // 0xFF reset command, no argument
        d0 = done_cnt; e0 = err_cnt; f0 = fwd_cnt;
        start_cmd(8'hFF, 1'b0, 8'h00);
        device_frame(cap);
        check("ff_frame", {21'b0, cap}, 32'h7FE);
        check("ff_inhibit_len", last_inh, 16);
        send_rx(8'hFA, fwd);
        check("ff_fa_gated", {31'b0, fwd}, 0);
        repeat (3) @(negedge clk);
        check("ff_done_pulses", done_cnt - d0, 1);
        check("ff_err_pulses", err_cnt - e0, 0);
        check("ff_fwd_count", fwd_cnt - f0, 0);
        check("ff_busy_end", {31'b0, cmd_busy}, 0);

        // 0xED with LED argument; stray request and scancode while waiting
        d0 = done_cnt; f0 = fwd_cnt; i0 = inh_cnt;
        start_cmd(8'hED, 1'b1, 8'h02);
        device_frame(cap);
        check("ed_frame", {21'b0, cap}, 32'h7DA);
        @(negedge clk);
        cmd_byte = 8'hAA;
        cmd_req = 1'b1;
        repeat (2) @(negedge clk);
        cmd_req = 1'b0;
        send_rx(8'h1C, fwd);
        check("wait_fwd_1c", {31'b0, fwd}, 1);
        send_rx(8'hFA, fwd);
        repeat (2) @(negedge clk);
        check("ed_no_early_done", done_cnt - d0, 0);
        device_frame(cap);
        check("ed_arg_frame", {21'b0, cap}, 32'h404);
        send_rx(8'hFA, fwd);
        repeat (3) @(negedge clk);
        check("ed_done_pulses", done_cnt - d0, 1);
        check("ed_fwd_count", fwd_cnt - f0, 1);
        check("ed_inhibits", inh_cnt - i0, 2);

        // 0xFE resend request for the argument only
        d0 = done_cnt; i0 = inh_cnt;
        start_cmd(8'hED, 1'b1, 8'h02);
        device_frame(cap);
        check("fe_cmd_frame", {21'b0, cap}, 32'h7DA);
        send_rx(8'hFA, fwd);
        device_frame(cap);
        check("fe_arg_frame", {21'b0, cap}, 32'h404);
        send_rx(8'hFE, fwd);
        check("fe_gated", {31'b0, fwd}, 0);
        device_frame(cap);
        check("fe_resent_frame", {21'b0, cap}, 32'h404);
        send_rx(8'hFA, fwd);
        repeat (3) @(negedge clk);
        check("fe_done_pulses", done_cnt - d0, 1);
        check("fe_inhibits", inh_cnt - i0, 3);

        // Silent keyboard: 1 + 2 retries spaced by timeouts, then error
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        start_cmd(8'hFF, 1'b0, 8'h00);
        err_at = 0;
        for (int k = 2; k < 2000 && err_at == 0; k++) begin
            @(negedge clk);
            if (cmd_err) err_at = k;
        end
        check("silent_err_time", {31'b0, (err_at >= 640 && err_at <= 660)}, 1);
        repeat (2) @(negedge clk);
        check("silent_err_pulses", err_cnt - e0, 1);
        check("silent_done_pulses", done_cnt - d0, 0);
        check("silent_inhibits", inh_cnt - i0, 3);
        check("silent_lines", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
        check("silent_busy", {31'b0, cmd_busy}, 0);

        // Reset in the middle of a frame, then a clean command
        start_cmd(8'hF0, 1'b0, 8'h00);
        wait_start(ok);
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (8) @(negedge clk);
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        check("midsend_data_low", {31'b0, ps2_data_oe}, 1);
        rst_n = 1'b0;
        #1;
        check("midsend_rst_lines", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
        check("midsend_rst_busy", {31'b0, cmd_busy}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        start_cmd(8'hFF, 1'b0, 8'h00);
        device_frame(cap);
        check("post_rst_frame", {21'b0, cap}, 32'h7FE);
        send_rx(8'hFA, fwd);
        repeat (3) @(negedge clk);
        check("post_rst_done", done_cnt - d0, 1);

        check("done_err_overlap", both_hi, 0);
        check("done_err_busy_edge", bad_edge, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
